crc_frame_packer: RTL and testbench

// - Upstream producer stage for the CRC verifier and link path: accepts raw data words on a

---
 rtl/crc_pkg.sv | 20 ++
 rtl/crc_generator_seq.sv | 77 +++++++
 rtl/crc_frame_packer.sv | 108 ++++++++++
 tb/tb_crc_frame_packer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and default constants for the CRC-4 frame packer and generator.
package crc_pkg;

  localparam int unsigned CRC4_WIDTH = 4;
  localparam int unsigned DATA_W     = 12;
  localparam logic [CRC4_WIDTH:0] CRC4_POLY = 5'b10011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CRC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Codeword layout at default widths: payload in MSBs, CRC in LSBs.
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [CRC4_WIDTH-1:0] crc;
  } codeword_t;

endpackage

// File: rtl/crc_generator_seq.sv
// Sequential MSB-first CRC generator: one job per start pulse, one-cycle done pulse with crc_out.
module crc_generator_seq
  import crc_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH        = DATA_W,
  parameter int unsigned          CRC_WIDTH         = CRC4_WIDTH,
  parameter logic [CRC_WIDTH:0]   POLY              = CRC4_POLY,
  parameter logic [CRC_WIDTH-1:0] SEED              = '0,
  parameter int unsigned          XOR_OPS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  done,
  output logic [CRC_WIDTH-1:0]  crc_out
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  logic                  running;
  logic [CNT_W-1:0]      left;
  logic [CNT_W-1:0]      left_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [CRC_WIDTH-1:0]  crc;
  logic [CRC_WIDTH-1:0]  crc_nxt;
  logic                  fb;

  // Up to XOR_OPS_PER_CYCLE LFSR steps this cycle, stopping once all data bits are consumed.
  always_comb begin
    left_nxt  = left;
    shreg_nxt = shreg;
    crc_nxt   = crc;
    fb        = 1'b0;
    for (int unsigned i = 0; i < XOR_OPS_PER_CYCLE; i++) begin
      if (left_nxt != '0) begin
        fb        = shreg_nxt[DATA_WIDTH-1] ^ crc_nxt[CRC_WIDTH-1];
        crc_nxt   = {crc_nxt[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY[CRC_WIDTH-1:0] : '0);
        shreg_nxt = {shreg_nxt[DATA_WIDTH-2:0], 1'b0};
        left_nxt  = left_nxt - CNT_W'(1);
      end
    end
  end

  // Job load on start, stepping while running, done pulse on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      left    <= '0;
      shreg   <= '0;
      crc     <= '0;
      done    <= 1'b0;
      crc_out <= '0;
    end else begin
      done <= 1'b0;
      if (!running) begin
        if (start) begin
          shreg   <= data;
          crc     <= SEED;
          left    <= CNT_W'(DATA_WIDTH);
          running <= 1'b1;
        end
      end else begin
        shreg <= shreg_nxt;
        crc   <= crc_nxt;
        left  <= left_nxt;
        if (left_nxt == '0) begin
          running <= 1'b0;
          done    <= 1'b1;
          crc_out <= crc_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/crc_frame_packer.sv
// Accepts data words, runs one CRC job per word and emits {data, crc} codewords.
module crc_frame_packer
  import crc_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH        = DATA_W,
  parameter int unsigned          CRC_WIDTH         = CRC4_WIDTH,
  parameter logic [CRC_WIDTH:0]   POLY              = CRC4_POLY,
  parameter logic [CRC_WIDTH-1:0] SEED              = '0,
  parameter int unsigned          XOR_OPS_PER_CYCLE = 1,
  // Reset value of the delivered-frame counter; nonzero only to exercise wrap quickly.
  parameter logic [15:0]          FRAME_CNT_RESET   = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH+CRC_WIDTH-1:0] m_data,
  output logic                            busy,
  output logic [15:0]                     frame_cnt
);

  localparam int unsigned CW_W = DATA_WIDTH + CRC_WIDTH;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] payload;
  logic [DATA_WIDTH-1:0] payload_nxt;
  logic                  m_valid_nxt;
  logic [CW_W-1:0]       m_data_nxt;
  logic [15:0]           frame_cnt_nxt;
  logic                  gen_start;
  logic                  gen_done;
  logic [CRC_WIDTH-1:0]  gen_crc;

  crc_generator_seq #(
    .DATA_WIDTH       (DATA_WIDTH),
    .CRC_WIDTH        (CRC_WIDTH),
    .POLY             (POLY),
    .SEED             (SEED),
    .XOR_OPS_PER_CYCLE(XOR_OPS_PER_CYCLE)
  ) u_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (gen_start),
    .data   (payload_nxt),
    .done   (gen_done),
    .crc_out(gen_crc)
  );

  // Next-state and datapath decode; done is only honoured in S_CRC.
  always_comb begin
    state_nxt     = state;
    payload_nxt   = payload;
    m_valid_nxt   = m_valid;
    m_data_nxt    = m_data;
    frame_cnt_nxt = frame_cnt;
    gen_start     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (s_valid) begin
          payload_nxt = s_data;
          gen_start   = 1'b1;
          state_nxt   = S_CRC;
        end
      end
      S_CRC: begin
        if (gen_done) begin
          m_data_nxt  = {payload, gen_crc};
          m_valid_nxt = 1'b1;
          state_nxt   = S_OUT;
        end
      end
      S_OUT: begin
        if (m_ready) begin
          m_valid_nxt   = 1'b0;
          frame_cnt_nxt = frame_cnt + 16'd1;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; s_ready/busy are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      payload   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      frame_cnt <= FRAME_CNT_RESET;
      busy      <= 1'b0;
      s_ready   <= 1'b1;
    end else begin
      state     <= state_nxt;
      payload   <= payload_nxt;
      m_valid   <= m_valid_nxt;
      m_data    <= m_data_nxt;
      frame_cnt <= frame_cnt_nxt;
      busy      <= (state_nxt != S_IDLE);
      s_ready   <= (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_crc_frame_packer.sv
// Directed bench for crc_frame_packer at one and four LFSR steps per cycle.
module tb_crc_frame_packer;

  localparam logic [15:0] POLY16 = 16'h0013;

  logic        clk;
  logic        rst_n;

  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        busy;
  logic [15:0] frame_cnt;

  logic        b_s_valid;
  logic        b_s_ready;
  logic [11:0] b_s_data;
  logic        b_m_valid;
  logic        b_m_ready;
  logic [15:0] b_m_data;
  logic        b_busy;
  logic [15:0] b_frame_cnt;

  int          checks;
  int          errors;
  logic [15:0] cnt_a;
  logic [15:0] exp_tab [8];

  crc_frame_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  crc_frame_packer #(
    .XOR_OPS_PER_CYCLE(4),
    .FRAME_CNT_RESET  (16'hFFFD)
  ) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (b_s_valid),
    .s_ready  (b_s_ready),
    .s_data   (b_s_data),
    .m_valid  (b_m_valid),
    .m_ready  (b_m_ready),
    .m_data   (b_m_data),
    .busy     (b_busy),
    .frame_cnt(b_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Polynomial long division remainder of a 16-bit value by x^4+x+1.
  function automatic logic [3:0] rem16(input logic [15:0] v_in);
    logic [15:0] v;
    v = v_in;
    for (int i = 15; i >= 4; i--) begin
      if (v[i]) v = v ^ (POLY16 << (i - 4));
    end
    return v[3:0];
  endfunction

  task automatic put_a(input logic [11:0] d);
    int   n;
    logic rdy;
    n       = 0;
    s_data  = d;
    s_valid = 1'b1;
    do begin
      rdy = s_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 100);
    chk("s_hs_timeout", 32'(rdy), 32'd1);
    #1;
    s_valid = 1'b0;
    s_data  = ~d;
  endtask

  task automatic wait_m_a(output int lat);
    lat = 0;
    while (!m_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("m_valid_timeout", 32'(m_valid), 32'd1);
  endtask

  task automatic pack_a(input logic [11:0] d, input logic [15:0] exp, input int hold, output int lat);
    int bad;
    m_ready = (hold == 0);
    put_a(d);
    wait_m_a(lat);
    chk("m_data", 32'(m_data), 32'(exp));
    chk("busy_out", 32'(busy), 32'd1);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      if (m_data !== exp || s_ready !== 1'b0 || m_valid !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    chk("backpressure_stable", 32'(bad), 32'd0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    cnt_a   = cnt_a + 16'd1;
    chk("m_valid_drop", 32'(m_valid), 32'd0);
    chk("frame_cnt", 32'(frame_cnt), 32'(cnt_a));
    chk("s_ready_back", 32'(s_ready), 32'd1);
  endtask

  task automatic pack_b(input logic [11:0] d, input logic [15:0] exp, input logic [15:0] exp_cnt,
                        output int lat);
    int   n;
    logic rdy;
    n         = 0;
    b_m_ready = 1'b1;
    b_s_data  = d;
    b_s_valid = 1'b1;
    do begin
      rdy = b_s_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 100);
    chk("b_s_hs_timeout", 32'(rdy), 32'd1);
    #1;
    b_s_valid = 1'b0;
    b_s_data  = ~d;
    lat = 0;
    while (!b_m_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b_m_valid_timeout", 32'(b_m_valid), 32'd1);
    chk("b_m_data", 32'(b_m_data), 32'(exp));
    @(posedge clk);
    #1;
    chk("b_m_valid_drop", 32'(b_m_valid), 32'd0);
    chk("b_frame_cnt", 32'(b_frame_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int          lat_a;
    int          lat_b;
    int          lat_tmp;
    int          in_i;
    int          out_i;
    int          cyc;
    int          seen;
    logic        s_hs;
    logic        m_hs;
    logic [15:0] mdat;

    checks    = 0;
    errors    = 0;
    cnt_a     = 16'd0;
    exp_tab   = '{16'h100F, 16'h101C, 16'h1029, 16'h103A, 16'h1043, 16'h1050, 16'h1065, 16'h1076};
    rst_n     = 1'b1;
    s_valid   = 1'b0;
    s_data    = 12'h0;
    m_ready   = 1'b0;
    b_s_valid = 1'b0;
    b_s_data  = 12'h0;
    b_m_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frames, m_ready already high before m_valid.
    pack_a(12'hABC, 16'hABCA, 0, lat_a);
    pack_a(12'h000, 16'h0000, 0, lat_tmp);
    pack_a(12'h001, 16'h0013, 0, lat_tmp);

    // Backpressure for 20 cycles.
    pack_a(12'hABC, 16'hABCA, 20, lat_tmp);

    // Streaming with s_valid held and random m_ready.
    in_i  = 0;
    out_i = 0;
    cyc   = 0;
    while (out_i < 8 && cyc < 2000) begin
      s_valid = (in_i < 8);
      s_data  = (in_i < 8) ? 12'(32'h100 + in_i) : 12'h000;
      m_ready = 1'($urandom_range(0, 1));
      s_hs    = s_valid && s_ready;
      m_hs    = m_valid && m_ready;
      mdat    = m_data;
      @(posedge clk);
      #1;
      cyc++;
      if (s_hs) in_i++;
      if (m_hs) begin
        chk("stream_data", 32'(mdat), 32'(exp_tab[out_i]));
        chk("stream_model", 32'(mdat[3:0]), 32'(rem16({mdat[15:4], 4'b0000})));
        chk("stream_verify", 32'(rem16(mdat)), 32'd0);
        out_i++;
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    cnt_a   = cnt_a + 16'(out_i);
    chk("stream_out_count", 32'(out_i), 32'd8);
    chk("stream_in_count", 32'(in_i), 32'd8);
    chk("stream_frame_cnt", 32'(frame_cnt), 32'(cnt_a));

    // Reset while the CRC job is running.
    m_ready = 1'b1;
    put_a(12'h5A5);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_crc_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_crc_m_valid", 32'(m_valid), 32'd0);
    chk("abort_crc_busy", 32'(busy), 32'd0);
    chk("abort_crc_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt_a = 16'd0;
    seen  = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (m_valid) seen++;
    end
    chk("abort_crc_no_out", 32'(seen), 32'd0);
    pack_a(12'h001, 16'h0013, 0, lat_tmp);

    // Reset while a codeword is waiting on m_ready.
    m_ready = 1'b0;
    put_a(12'h777);
    wait_m_a(lat_tmp);
    rst_n = 1'b0;
    #1;
    chk("abort_out_m_valid", 32'(m_valid), 32'd0);
    chk("abort_out_m_data", 32'(m_data), 32'd0);
    chk("abort_out_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cnt_a   = 16'd0;
    m_ready = 1'b1;
    seen    = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (m_valid) seen++;
    end
    chk("abort_out_no_out", 32'(seen), 32'd0);
    pack_a(12'hABC, 16'hABCA, 0, lat_tmp);

    // Four steps per cycle: same codewords, shorter latency, counter wrap.
    pack_b(12'hABC, 16'hABCA, 16'hFFFE, lat_b);
    chk("lat_faster", 32'(lat_b < lat_a), 32'd1);
    pack_b(12'h000, 16'h0000, 16'hFFFF, lat_tmp);
    pack_b(12'h001, 16'h0013, 16'h0000, lat_tmp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
